// File: rtl/sram_pkg.sv
// sram_pkg: shared states, default timing, op and bitline-mode encodings
package sram_pkg;
  typedef enum logic [2:0] {IDLE, PRECHARGE, ACCESS, SENSE, DONE} state_t;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
  typedef enum logic [1:0] {BL_RELEASE, BL_PRECHARGE, BL_WRITE} bl_mode_t;
  localparam int SRAM_PRE_CYCLES = 2;
  localparam int SRAM_WL_CYCLES = 3;
endpackage

// File: rtl/sram_bitline_driver.sv
// sram_bitline_driver: tristate driver for one bl/blb pair, returns sampled bl
module sram_bitline_driver
  import sram_pkg::*;
(
  input  bl_mode_t mode,
  input  logic     d,
  inout  wire      bl,
  inout  wire      blb,
  output logic     q
);
  assign bl  = mode == BL_PRECHARGE ? 1'b1 : mode == BL_WRITE ? d : 1'bz;
  assign blb = mode == BL_PRECHARGE ? 1'b1 : mode == BL_WRITE ? ~d : 1'bz;
  assign q   = bl;
endmodule

// File: rtl/sram_col_ctrl.sv
// sram_col_ctrl: precharge/access/sense sequencer for one SRAM word column group
// Optional differential sense check built when SRAM_SENSE_CHECK_EN is defined.
module sram_col_ctrl
  import sram_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRE_CYCLES = SRAM_PRE_CYCLES,
  parameter int WL_CYCLES  = SRAM_WL_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] sense_err,
  output logic             wl,
  inout  wire  [WIDTH-1:0] bl,
  inout  wire  [WIDTH-1:0] blb
);
  localparam int MAXC = PRE_CYCLES > WL_CYCLES ? PRE_CYCLES : WL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  if (PRE_CYCLES < 1) begin : g_bad_pre
    $error("PRE_CYCLES must be >= 1");
  end
  if (WL_CYCLES < 1) begin : g_bad_wl
    $error("WL_CYCLES must be >= 1");
  end
  state_t           state;
  op_t              op_q;
  bl_mode_t         mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] bl_s;
  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    sram_bitline_driver u_drv (
      .mode(mode),
      .d   (wdata_q[i]),
      .bl  (bl[i]),
      .blb (blb[i]),
      .q   (bl_s[i])
    );
  end
`ifdef SRAM_SENSE_CHECK_EN
  logic [WIDTH-1:0] diff_ok;
  always_comb begin
    diff_ok = '0;
    for (int i = 0; i < WIDTH; i++) diff_ok[i] = (bl[i] ^ blb[i]) === 1'b1;
  end
`else
  assign sense_err = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_READ;
      mode    <= BL_RELEASE;
      cnt     <= '0;
      wdata_q <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      wl      <= 1'b0;
      rdata   <= '0;
`ifdef SRAM_SENSE_CHECK_EN
      sense_err <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          state   <= PRECHARGE;
          op_q    <= op_t'(we);
          wdata_q <= wdata;
          mode    <= BL_PRECHARGE;
          cnt     <= '0;
          ready   <= 1'b0;
`ifdef SRAM_SENSE_CHECK_EN
          sense_err <= '0;
`endif
        end
        PRECHARGE: if (cnt == CW'(PRE_CYCLES - 1)) begin
          state <= ACCESS;
          cnt   <= '0;
          wl    <= 1'b1;
          mode  <= op_q == OP_WRITE ? BL_WRITE : BL_RELEASE;
        end else cnt <= cnt + CW'(1);
        ACCESS: if (cnt == CW'(WL_CYCLES - 1)) begin
          cnt   <= '0;
          mode  <= BL_RELEASE;
          state <= op_q == OP_WRITE ? DONE : SENSE;
          wl    <= op_q != OP_WRITE;
          done  <= op_q == OP_WRITE;
        end else cnt <= cnt + CW'(1);
        SENSE: begin
          state <= DONE;
          wl    <= 1'b0;
          done  <= 1'b1;
`ifdef SRAM_SENSE_CHECK_EN
          rdata     <= bl_s & diff_ok;
          sense_err <= ~diff_ok;
`else
          rdata <= bl_s;
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_col_ctrl.sv
// tb_sram_col_ctrl: directed checks of sram_col_ctrl with a one-word cell model on the bitlines
module tb_sram_col_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [7:0] wdata = '0;
  logic       ready, done, wl;
  logic [7:0] rdata, sense_err;
  wire  [7:0] bl, blb;
  logic [7:0] mem = '0;
  logic [7:0] col_mask = 8'hFF;
  logic       cell_rd = 1'b0;
  logic       probe = 1'b0;
  logic       cell_drv;
  int         checks = 0;
  int         errors = 0;
  int         dones;

  always #5 clk = ~clk;

  sram_col_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .sense_err(sense_err),
    .wl(wl), .bl(bl), .blb(blb)
  );

  assign cell_drv = (wl & cell_rd) | probe;
  for (genvar i = 0; i < 8; i++) begin : g_cell
    assign bl[i]  = cell_drv && col_mask[i] ? mem[i] : 1'bz;
    assign blb[i] = cell_drv && col_mask[i] ? ~mem[i] : 1'bz;
  end
  always @(posedge clk) if (wl && !cell_rd) mem <= bl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench #1 into cycle 1 of the accepted operation
  task automatic start(input logic w, input logic [7:0] d);
    int n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", {31'b0, ready}, 1);
    req = 1'b1; we = w; wdata = d;
    step();
    req = 1'b0; we = ~w; wdata = ~d;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    check("rst_ready", {31'b0, ready}, 1);
    check("rst_done", {31'b0, done}, 0);
    check("rst_wl", {31'b0, wl}, 0);
    check("rst_rdata", {24'b0, rdata}, 0);
    check("rst_serr", {24'b0, sense_err}, 0);

    // write 0xA5
    cell_rd = 1'b0;
    start(1'b1, 8'hA5);
    check("wr_c1_wl", {31'b0, wl}, 0);
    check("wr_c1_ready", {31'b0, ready}, 0);
    check("wr_c1_bl", {24'b0, bl}, 32'hFF);
    check("wr_c1_blb", {24'b0, blb}, 32'hFF);
    step(); step();
    for (int c = 3; c <= 5; c++) begin
      check("wr_acc_wl", {31'b0, wl}, 1);
      check("wr_acc_bl", {24'b0, bl}, 32'hA5);
      check("wr_acc_blb", {24'b0, blb}, 32'h5A);
      check("wr_acc_done", {31'b0, done}, 0);
      step();
    end
    check("wr_c6_done", {31'b0, done}, 1);
    check("wr_c6_wl", {31'b0, wl}, 0);
    check("wr_c6_ready", {31'b0, ready}, 0);
    step();
    check("wr_c7_ready", {31'b0, ready}, 1);
    check("wr_c7_done", {31'b0, done}, 0);
    check("wr_rdata_kept", {24'b0, rdata}, 0);

    // read back 0xA5
    cell_rd = 1'b1;
    start(1'b0, 8'h00);
    check("rd_c1_bl", {24'b0, bl}, 32'hFF);
    check("rd_c1_blb", {24'b0, blb}, 32'hFF);
    step();
    check("rd_c2_bl", {24'b0, bl}, 32'hFF);
    check("rd_c2_wl", {31'b0, wl}, 0);
    step(); step(); step(); step();
    check("rd_c6_wl", {31'b0, wl}, 1);
    check("rd_c6_done", {31'b0, done}, 0);
    step();
    check("rd_c7_done", {31'b0, done}, 1);
    check("rd_c7_rdata", {24'b0, rdata}, 32'hA5);
    check("rd_c7_wl", {31'b0, wl}, 0);
    step();
    check("rd_c8_ready", {31'b0, ready}, 1);

    // reset for 3 cycles in the middle of a write's ACCESS phase
    cell_rd = 1'b0;
    start(1'b1, 8'h11);
    step(); step(); step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("mid_rst_wl", {31'b0, wl}, 0);
    check("mid_rst_ready", {31'b0, ready}, 1);
    check("mid_rst_done", {31'b0, done}, 0);
    check("mid_rst_rdata", {24'b0, rdata}, 0);
    probe = 1'b1;
    #1;
    check("mid_rst_bl_free", {24'b0, bl}, {24'b0, mem});
    check("mid_rst_blb_free", {24'b0, blb}, {24'b0, ~mem});
    probe = 1'b0;

    // req pulsed while busy must be ignored
    cell_rd = 1'b1;
    start(1'b0, 8'h00);
    dones = 0;
    for (int c = 2; c <= 20; c++) begin
      step();
      req = (c >= 2 && c <= 6);
      if (c == 7) check("busy_c7_rdata", {24'b0, rdata}, 32'h11);
      if (done) dones++;
    end
    req = 1'b0;
    check("busy_one_done", dones, 1);
    check("busy_ready", {31'b0, ready}, 1);

    // write 0x3C then a held-req read, accepted on the first ready cycle
    cell_rd = 1'b0;
    req = 1'b1; we = 1'b1; wdata = 8'h3C;
    step();
    we = 1'b0; wdata = 8'hFF;
    for (int c = 2; c <= 7; c++) step();
    check("b2b_c7_ready", {31'b0, ready}, 1);
    cell_rd = 1'b1;
    step();
    req = 1'b0;
    check("b2b_accept", {31'b0, ready}, 0);
    check("b2b_pre_bl", {24'b0, bl}, 32'hFF);
    repeat (6) step();
    check("b2b_rd_done", {31'b0, done}, 1);
    check("b2b_rd_rdata", {24'b0, rdata}, 32'h3C);

    // column 2 floating during a read
    col_mask = 8'hFB;
    start(1'b0, 8'h00);
    repeat (6) step();
    check("sc_done", {31'b0, done}, 1);
`ifdef SRAM_SENSE_CHECK_EN
    check("sc_serr", {24'b0, sense_err}, 32'h04);
    check("sc_rdata", {24'b0, rdata}, 32'h38);
`else
    check("sc_serr", {24'b0, sense_err}, 0);
    check("sc_rdata", {24'b0, rdata & 8'hFB}, 32'h38);
`endif
    col_mask = 8'hFF;
    start(1'b0, 8'h00);
    check("sc_clear", {24'b0, sense_err}, 0);
    repeat (6) step();
    check("sc_clean_rdata", {24'b0, rdata}, 32'h3C);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
